// File: rtl/axi_full_pkg.sv
// Shared widths, response codes, state encodings and the 4 KB crossing check
// for the AXI4-full memory responder.
package axi_full_pkg;

    localparam int ID_W   = 1;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 128;
    localparam int STRB_W = DATA_W / 8;
    localparam int LEN_W  = 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_16B   = 3'd4;

    typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_e;
    typedef enum logic       {RD_IDLE, RD_DATA}          rd_state_e;

    // The byte offset inside the beat is ignored; the burst may end exactly on the page edge.
    function automatic logic crosses_4k(input logic [11:0] addr, input logic [LEN_W-1:0] len);
        logic [13:0] span_end;
        span_end = ({2'b00, addr} & 14'h3FF0) + ({6'b000000, len} + 14'd1) * 14'd16;
        return span_end > 14'd4096;
    endfunction

endpackage

// File: rtl/axi_slave_ram.sv
// Simple dual-port RAM: byte-enabled write port and registered, enabled read port.
// A read and write to the same word in one cycle returns the old contents.
module axi_slave_ram
    import axi_full_pkg::*;
#(
    parameter int DATA_W = axi_full_pkg::DATA_W,
    parameter int DEPTH  = 4096,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                we,
    input  logic [IDX_W-1:0]    waddr,
    input  logic [DATA_W/8-1:0] be,
    input  logic [DATA_W-1:0]   wdata,
    input  logic                re,
    input  logic [IDX_W-1:0]    raddr,
    output logic [DATA_W-1:0]   rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < DATA_W / 8; i++) begin
                if (be[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/axi_full_slave_mem.sv
// AXI4-full responder with one write and one read burst outstanding, INCR bursts only,
// fronting a dual-port RAM. Illegal or unmapped bursts are answered with SLVERR/DECERR.
module axi_full_slave_mem
    import axi_full_pkg::*;
#(
    parameter int          C_M_AXI_ID_WIDTH   = 1,
    parameter int          C_M_AXI_ADDR_WIDTH = 32,
    parameter int          C_M_AXI_DATA_WIDTH = 128,
    parameter logic [31:0] MEM_BASE           = 32'h1000_0000,
    parameter int          MEM_BYTES          = 65536,
    parameter int          READY_STALL        = 0
) (
    input  logic                            M_AXI_ACLK,
    input  logic                            M_AXI_ARESET,
    input  logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_AWID,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    input  logic [7:0]                      M_AXI_AWLEN,
    input  logic [2:0]                      M_AXI_AWSIZE,
    input  logic [1:0]                      M_AXI_AWBURST,
    input  logic                            M_AXI_AWLOCK,
    input  logic [3:0]                      M_AXI_AWCACHE,
    input  logic [2:0]                      M_AXI_AWPROT,
    input  logic [3:0]                      M_AXI_AWQOS,
    input  logic                            M_AXI_AWUSER,
    input  logic                            M_AXI_AWVALID,
    output logic                            M_AXI_AWREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    input  logic                            M_AXI_WLAST,
    input  logic                            M_AXI_WUSER,
    input  logic                            M_AXI_WVALID,
    output logic                            M_AXI_WREADY,
    output logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_BID,
    output logic [1:0]                      M_AXI_BRESP,
    output logic                            M_AXI_BUSER,
    output logic                            M_AXI_BVALID,
    input  logic                            M_AXI_BREADY,
    input  logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_ARID,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    input  logic [7:0]                      M_AXI_ARLEN,
    input  logic [2:0]                      M_AXI_ARSIZE,
    input  logic [1:0]                      M_AXI_ARBURST,
    input  logic                            M_AXI_ARLOCK,
    input  logic [3:0]                      M_AXI_ARCACHE,
    input  logic [2:0]                      M_AXI_ARPROT,
    input  logic [3:0]                      M_AXI_ARQOS,
    input  logic                            M_AXI_ARUSER,
    input  logic                            M_AXI_ARVALID,
    output logic                            M_AXI_ARREADY,
    output logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_RID,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    output logic [1:0]                      M_AXI_RRESP,
    output logic                            M_AXI_RLAST,
    output logic                            M_AXI_RUSER,
    output logic                            M_AXI_RVALID,
    input  logic                            M_AXI_RREADY,
    output logic [15:0]                     err_count,
    output logic                            wlast_err
);

    localparam int AW      = C_M_AXI_ADDR_WIDTH;
    localparam int WORDS   = MEM_BYTES / (C_M_AXI_DATA_WIDTH / 8);
    localparam int IDX_W   = $clog2(WORDS);
    localparam int STALL_W = (READY_STALL > 0) ? $clog2(READY_STALL + 1) : 1;

    function automatic logic [1:0] check_burst(input logic [AW-1:0] addr, input logic [7:0] len,
                                               input logic [2:0] size, input logic [1:0] burst);
        logic [AW:0] start_a, end_a, base_a, limit_a;
        logic [1:0]  resp;
        base_a  = (AW+1)'(MEM_BASE);
        limit_a = base_a + (AW+1)'(MEM_BYTES);
        start_a = {1'b0, addr[AW-1:4], 4'b0000};
        end_a   = start_a + (((AW+1)'(len) + (AW+1)'(1)) << 4);
        resp    = RESP_OKAY;
        if (start_a < base_a || end_a > limit_a)
            resp = RESP_DECERR;
        else if (size != SIZE_16B || burst != BURST_INCR || crosses_4k(addr[11:0], len))
            resp = RESP_SLVERR;
        return resp;
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [AW-1:0] addr);
        return IDX_W'((addr - AW'(MEM_BASE)) >> 4);
    endfunction

    wr_state_e                  wr_state, wr_next;
    rd_state_e                  rd_state, rd_next;
    logic [STALL_W-1:0]         aw_stall, ar_stall;
    logic [C_M_AXI_ID_WIDTH-1:0] wr_id, rd_id;
    logic [1:0]                 wr_resp, rd_resp;
    logic [IDX_W-1:0]           wr_idx, rd_idx, ram_raddr;
    logic [7:0]                 wr_beat, wr_len, rd_beat, rd_len;
    logic                       aw_hs, w_hs, b_hs, ar_hs, r_hs, ram_we, ram_re;
    logic [C_M_AXI_DATA_WIDTH-1:0] ram_q;
    logic [1:0]                 err_inc;
    logic [16:0]                err_sum;
    logic                       unused_inputs;

    assign unused_inputs = ^{M_AXI_AWLOCK, M_AXI_AWCACHE, M_AXI_AWPROT, M_AXI_AWQOS, M_AXI_AWUSER,
                             M_AXI_ARLOCK, M_AXI_ARCACHE, M_AXI_ARPROT, M_AXI_ARQOS, M_AXI_ARUSER,
                             M_AXI_WUSER};

    assign aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_hs  = M_AXI_WVALID && M_AXI_WREADY;
    assign b_hs  = M_AXI_BVALID && M_AXI_BREADY;
    assign ar_hs = M_AXI_ARVALID && M_AXI_ARREADY;
    assign r_hs  = M_AXI_RVALID && M_AXI_RREADY;

    assign M_AXI_BID   = wr_id;
    assign M_AXI_BRESP = wr_resp;
    assign M_AXI_BUSER = 1'b0;
    assign M_AXI_RID   = rd_id;
    assign M_AXI_RRESP = rd_resp;
    assign M_AXI_RUSER = 1'b0;

    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            wr_state <= WR_IDLE;
            rd_state <= RD_IDLE;
        end else begin
            wr_state <= wr_next;
            rd_state <= rd_next;
        end
    end

    always_comb begin
        wr_next = wr_state;
        case (wr_state)
            WR_IDLE: if (aw_hs) wr_next = WR_DATA;
            WR_DATA: if (w_hs && wr_beat == wr_len) wr_next = WR_RESP;
            WR_RESP: if (M_AXI_BREADY) wr_next = WR_IDLE;
            default: wr_next = WR_IDLE;
        endcase
        rd_next = rd_state;
        case (rd_state)
            RD_IDLE: if (ar_hs) rd_next = RD_DATA;
            RD_DATA: if (r_hs && rd_beat == rd_len) rd_next = RD_IDLE;
            default: rd_next = RD_IDLE;
        endcase
    end

    // Address READY is combinational on VALID once the stall counter has run out.
    always_comb begin
        M_AXI_AWREADY = (wr_state == WR_IDLE) && M_AXI_AWVALID && !M_AXI_ARESET
                        && (aw_stall == STALL_W'(READY_STALL));
        M_AXI_WREADY  = (wr_state == WR_DATA);
        M_AXI_BVALID  = (wr_state == WR_RESP);
        M_AXI_ARREADY = (rd_state == RD_IDLE) && M_AXI_ARVALID && !M_AXI_ARESET
                        && (ar_stall == STALL_W'(READY_STALL));
        M_AXI_RVALID  = (rd_state == RD_DATA);
        M_AXI_RLAST   = (rd_state == RD_DATA) && (rd_beat == rd_len);
        M_AXI_RDATA   = ((rd_state == RD_DATA) && (rd_resp == RESP_OKAY)) ? ram_q : '0;
    end

    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            aw_stall  <= '0;
            wr_id     <= '0;
            wr_resp   <= RESP_OKAY;
            wr_idx    <= '0;
            wr_beat   <= '0;
            wr_len    <= '0;
            wlast_err <= 1'b0;
        end else begin
            wlast_err <= 1'b0;
            if (wr_state == WR_IDLE && M_AXI_AWVALID && !aw_hs) aw_stall <= aw_stall + STALL_W'(1);
            else aw_stall <= '0;
            if (aw_hs) begin
                wr_id   <= M_AXI_AWID;
                wr_resp <= check_burst(M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST);
                wr_idx  <= word_idx(M_AXI_AWADDR);
                wr_beat <= '0;
                wr_len  <= M_AXI_AWLEN;
            end
            if (w_hs) begin
                wr_idx  <= wr_idx + IDX_W'(1);
                wr_beat <= wr_beat + 8'd1;
                if (M_AXI_WLAST != (wr_beat == wr_len)) begin
                    wlast_err <= 1'b1;
                    if (wr_resp != RESP_DECERR) wr_resp <= RESP_SLVERR;
                end
            end
        end
    end

    // The first beat is fetched during the AR handshake so RVALID can rise on the next cycle.
    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            ar_stall <= '0;
            rd_id    <= '0;
            rd_resp  <= RESP_OKAY;
            rd_idx   <= '0;
            rd_beat  <= '0;
            rd_len   <= '0;
        end else begin
            if (rd_state == RD_IDLE && M_AXI_ARVALID && !ar_hs) ar_stall <= ar_stall + STALL_W'(1);
            else ar_stall <= '0;
            if (ar_hs) begin
                rd_id   <= M_AXI_ARID;
                rd_resp <= check_burst(M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST);
                rd_idx  <= word_idx(M_AXI_ARADDR) + IDX_W'(1);
                rd_beat <= '0;
                rd_len  <= M_AXI_ARLEN;
            end else if (r_hs) begin
                rd_idx  <= rd_idx + IDX_W'(1);
                rd_beat <= rd_beat + 8'd1;
            end
        end
    end

    assign ram_we    = w_hs && (wr_resp == RESP_OKAY);
    assign ram_re    = ar_hs || (r_hs && !M_AXI_RLAST);
    assign ram_raddr = (rd_state == RD_IDLE) ? word_idx(M_AXI_ARADDR) : rd_idx;

    axi_slave_ram #(
        .DATA_W (C_M_AXI_DATA_WIDTH),
        .DEPTH  (WORDS),
        .IDX_W  (IDX_W)
    ) u_ram (
        .clk   (M_AXI_ACLK),
        .we    (ram_we),
        .waddr (wr_idx),
        .be    (M_AXI_WSTRB),
        .wdata (M_AXI_WDATA),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_q)
    );

    // A B and a final R error can land in the same cycle, so the step can be two.
    assign err_inc = {1'b0, b_hs && (wr_resp != RESP_OKAY)}
                   + {1'b0, r_hs && M_AXI_RLAST && (rd_resp != RESP_OKAY)};
    assign err_sum = {1'b0, err_count} + {15'd0, err_inc};

    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) err_count <= '0;
        else err_count <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end

endmodule

// File: tb/tb_axi_full_slave_mem.sv
// Randomized bench for axi_full_slave_mem: directed bursts plus random traffic,
// all checked against a word-array memory model and the address-rule response model.
module tb_axi_full_slave_mem;

    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam int          BYTES = 65536;
    localparam int          STALL = 3;
    localparam logic [1:0]  OKAY = 2'd0, SLVERR = 2'd2, DECERR = 2'd3;

    logic         clk, rst;
    logic [0:0]   aw_id, b_id, ar_id, r_id;
    logic [31:0]  aw_addr, ar_addr;
    logic [7:0]   aw_len, ar_len;
    logic [2:0]   aw_size, ar_size;
    logic [1:0]   aw_burst, ar_burst, b_resp, r_resp;
    logic         aw_valid, aw_ready, w_last, w_valid, w_ready, b_user, b_valid, b_ready;
    logic         ar_valid, ar_ready, r_last, r_user, r_valid, r_ready, wlast_err;
    logic [127:0] w_data, r_data;
    logic [15:0]  w_strb, err_count;

    int           checks = 0, passed = 0, errExp = 0;
    logic [127:0] modelMem [512];
    logic [127:0] stimData [256];
    logic [15:0]  stimStrb [256];

    axi_full_slave_mem #(.READY_STALL(STALL)) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
        .M_AXI_AWID(aw_id), .M_AXI_AWADDR(aw_addr), .M_AXI_AWLEN(aw_len), .M_AXI_AWSIZE(aw_size),
        .M_AXI_AWBURST(aw_burst), .M_AXI_AWLOCK(1'b0), .M_AXI_AWCACHE(4'd0), .M_AXI_AWPROT(3'd0),
        .M_AXI_AWQOS(4'd0), .M_AXI_AWUSER(1'b0), .M_AXI_AWVALID(aw_valid), .M_AXI_AWREADY(aw_ready),
        .M_AXI_WDATA(w_data), .M_AXI_WSTRB(w_strb), .M_AXI_WLAST(w_last), .M_AXI_WUSER(1'b0),
        .M_AXI_WVALID(w_valid), .M_AXI_WREADY(w_ready),
        .M_AXI_BID(b_id), .M_AXI_BRESP(b_resp), .M_AXI_BUSER(b_user), .M_AXI_BVALID(b_valid),
        .M_AXI_BREADY(b_ready),
        .M_AXI_ARID(ar_id), .M_AXI_ARADDR(ar_addr), .M_AXI_ARLEN(ar_len), .M_AXI_ARSIZE(ar_size),
        .M_AXI_ARBURST(ar_burst), .M_AXI_ARLOCK(1'b0), .M_AXI_ARCACHE(4'd0), .M_AXI_ARPROT(3'd0),
        .M_AXI_ARQOS(4'd0), .M_AXI_ARUSER(1'b0), .M_AXI_ARVALID(ar_valid), .M_AXI_ARREADY(ar_ready),
        .M_AXI_RID(r_id), .M_AXI_RDATA(r_data), .M_AXI_RRESP(r_resp), .M_AXI_RLAST(r_last),
        .M_AXI_RUSER(r_user), .M_AXI_RVALID(r_valid), .M_AXI_RREADY(r_ready),
        .err_count(err_count), .wlast_err(wlast_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual === expected) passed++;
        else $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    endtask

    // Response predicted straight from the address rules: unmapped first, then illegal/4K-crossing.
    function automatic logic [1:0] expResp(input logic [31:0] addr, input int len,
                                           input logic [2:0] size, input logic [1:0] burst);
        longint startB, endB;
        startB = longint'({32'd0, addr[31:4], 4'd0});
        endB   = startB + longint'(len + 1) * 16;
        if (startB < longint'(BASE) || endB > longint'(BASE) + BYTES) return DECERR;
        if (size != 3'd4 || burst != 2'b01 || (startB % 4096) + (len + 1) * 16 > 4096) return SLVERR;
        return OKAY;
    endfunction

    function automatic int bumpErr(input int e);
        return (e >= 65535) ? 65535 : e + 1;
    endfunction

    task automatic doWrite(input logic [31:0] addr, input int len, input logic [2:0] size,
                           input logic [1:0] burst, input logic id, input int lastBeat, input int abortBeat);
        logic [1:0] resp;
        int         waits, word;
        bit         got, mism;
        resp = expResp(addr, len, size, burst);
        word = int'((addr - BASE) >> 4);
        aw_addr = addr; aw_len = 8'(len); aw_size = size; aw_burst = burst; aw_id = id; aw_valid = 1'b1;
        waits = 0; got = 0;
        while (!got && waits < 50) begin
            @(negedge clk); got = aw_ready;
            @(posedge clk); #1;
            if (!got) waits++;
        end
        aw_valid = 1'b0;
        checkOutput("aw_stall", waits, STALL);
        if (!got) return;
        for (int b = 0; b <= len; b++) begin
            w_data = stimData[b]; w_strb = stimStrb[b]; w_last = (b == lastBeat); w_valid = 1'b1;
            if (b == abortBeat) begin
                @(negedge clk); rst = 1'b1; #1;
                checkOutput("wready_rst", w_ready, 0);
                checkOutput("bvalid_rst", b_valid, 0);
                checkOutput("err_rst", err_count, 0);
                w_valid = 1'b0; w_last = 1'b0;
                @(posedge clk); #1;
                @(negedge clk); rst = 1'b0;
                @(posedge clk); #1;
                errExp = 0;
                return;
            end
            waits = 0; got = 0;
            while (!got && waits < 20) begin
                @(negedge clk); got = w_ready;
                @(posedge clk); #1;
                waits++;
            end
            if (!got) begin
                checkOutput("w_timeout", 0, 1);
                w_valid = 1'b0;
                return;
            end
            if (resp == OKAY)
                for (int k = 0; k < 16; k++)
                    if (stimStrb[b][k]) modelMem[word + b][k*8 +: 8] = stimData[b][k*8 +: 8];
            mism = ((b == lastBeat) != (b == len));
            if (mism && resp != DECERR) resp = SLVERR;
            checkOutput("wlast_err", wlast_err, mism);
        end
        w_valid = 1'b0; w_last = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        b_ready = 1'b1;
        waits = 0; got = 0;
        while (!got && waits < 20) begin
            @(negedge clk); got = b_valid;
            if (got) begin
                checkOutput("bresp", b_resp, resp);
                checkOutput("bid", b_id, id);
            end
            @(posedge clk); #1;
            waits++;
        end
        b_ready = 1'b0;
        if (!got) begin checkOutput("b_timeout", 0, 1); return; end
        if (resp != OKAY) errExp = bumpErr(errExp);
        checkOutput("err_count_b", err_count, errExp);
    endtask

    task automatic doRead(input logic [31:0] addr, input int len, input logic [2:0] size,
                          input logic [1:0] burst, input logic id, input int rmode);
        logic [1:0]   resp;
        logic [127:0] held, expData;
        int           waits, word, beat, cyc;
        bit           got, stalled;
        resp = expResp(addr, len, size, burst);
        word = int'((addr - BASE) >> 4);
        ar_addr = addr; ar_len = 8'(len); ar_size = size; ar_burst = burst; ar_id = id; ar_valid = 1'b1;
        waits = 0; got = 0;
        while (!got && waits < 50) begin
            @(negedge clk); got = ar_ready;
            @(posedge clk); #1;
            if (!got) waits++;
        end
        ar_valid = 1'b0;
        checkOutput("ar_stall", waits, STALL);
        if (!got) return;
        checkOutput("rvalid_lat", r_valid, 1);
        r_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
        beat = 0; cyc = 0; stalled = 0; held = '0;
        while (beat <= len && cyc < 2000) begin
            @(negedge clk);
            if (r_valid) begin
                if (stalled) checkOutput("rdata_hold", r_data, held);
                if (r_ready) begin
                    expData = (resp == OKAY) ? modelMem[word + beat] : '0;
                    checkOutput("rdata", r_data, expData);
                    checkOutput("rresp", r_resp, resp);
                    checkOutput("rid", r_id, id);
                    checkOutput("rlast", r_last, beat == len);
                    beat++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    held = r_data;
                end
            end
            @(posedge clk); #1;
            cyc++;
            r_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? ~r_ready : 1'($urandom_range(0, 1));
        end
        r_ready = 1'b0;
        if (beat <= len) begin checkOutput("r_timeout", beat, len + 1); return; end
        checkOutput("rvalid_end", r_valid, 0);
        if (resp != OKAY) errExp = bumpErr(errExp);
        checkOutput("err_count_r", err_count, errExp);
    endtask

    task automatic fillRandom(input int len, input bit fullStrb);
        for (int k = 0; k <= len; k++) begin
            stimData[k] = {$urandom, $urandom, $urandom, $urandom};
            stimStrb[k] = fullStrb ? 16'hFFFF : 16'($urandom_range(0, 65535));
        end
    endtask

    task automatic applyStimulus(input int nOps);
        for (int n = 0; n < nOps; n++) begin
            logic [31:0] addr;
            logic [2:0]  size;
            logic [1:0]  burst;
            int          len, sel;
            addr  = BASE + ($urandom_range(0, 511) << 4);
            len   = $urandom_range(0, 15);
            size  = 3'd4;
            burst = 2'b01;
            sel   = $urandom_range(0, 9);
            if (sel == 0) addr = ($urandom_range(0, 1) == 0) ? 32'h0FFF_FFF0 : 32'h1001_0000;
            else if (sel == 1) size = 3'd3;
            else if (sel == 2) burst = 2'b10;
            if ($urandom_range(0, 1) == 1) begin
                fillRandom(len, 1'b0);
                doWrite(addr, len, size, burst, 1'($urandom_range(0, 1)), len, -1);
            end else begin
                doRead(addr, len, size, burst, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        aw_id = '0; aw_addr = '0; aw_len = '0; aw_size = '0; aw_burst = '0; aw_valid = 1'b0;
        ar_id = '0; ar_addr = '0; ar_len = '0; ar_size = '0; ar_burst = '0; ar_valid = 1'b0;
        w_data = '0; w_strb = '0; w_last = 1'b0; w_valid = 1'b0; b_ready = 1'b0; r_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_wready", w_ready, 0);
        checkOutput("rst_bvalid", b_valid, 0);
        checkOutput("rst_rvalid", r_valid, 0);
        checkOutput("rst_rlast", r_last, 0);
        checkOutput("rst_rdata", r_data, 0);
        checkOutput("rst_err", err_count, 0);
        rst = 1'b0;

        fillRandom(255, 1'b1);
        doWrite(BASE, 255, 3'd4, 2'b01, 1'b0, 255, -1);
        fillRandom(255, 1'b1);
        doWrite(BASE + 32'h1000, 255, 3'd4, 2'b01, 1'b0, 255, -1);

        for (int k = 0; k < 4; k++) begin stimData[k] = 128'(k); stimStrb[k] = 16'hFFFF; end
        doWrite(BASE, 3, 3'd4, 2'b01, 1'b1, 3, -1);
        doRead(BASE, 3, 3'd4, 2'b01, 1'b1, 0);

        fillRandom(7, 1'b1);
        doWrite(BASE + 32'h0FC0, 7, 3'd4, 2'b01, 1'b0, 7, -1);
        doRead(BASE + 32'h0FC0, 3, 3'd4, 2'b01, 1'b0, 2);
        doRead(BASE + 32'h1000, 3, 3'd4, 2'b01, 1'b0, 0);

        stimData[0] = '1; stimStrb[0] = 16'hFFFF;
        doWrite(BASE + 32'h0100, 0, 3'd4, 2'b01, 1'b0, 0, -1);
        stimData[0] = 128'hAAAA_BBBB_CCCC_DDDD_EEEE_0000_1234_5678; stimStrb[0] = 16'h000F;
        doWrite(BASE + 32'h0100, 0, 3'd4, 2'b01, 1'b0, 0, -1);
        doRead(BASE + 32'h0100, 0, 3'd4, 2'b01, 1'b0, 0);

        doRead(BASE, 255, 3'd4, 2'b01, 1'b0, 1);

        doRead(32'h0000_0000, 1, 3'd4, 2'b01, 1'b0, 0);
        doRead(32'h1000_FFF0, 1, 3'd4, 2'b01, 1'b1, 0);
        fillRandom(1, 1'b1);
        doWrite(BASE + 32'h0200, 1, 3'd4, 2'b01, 1'b1, 0, -1);
        fillRandom(1, 1'b1);
        doWrite(BASE + 32'h0200, 1, 3'd4, 2'b01, 1'b0, 1, -1);
        doRead(BASE + 32'h0200, 1, 3'd4, 2'b01, 1'b0, 0);

        fillRandom(3, 1'b1);
        doWrite(BASE + 32'h0300, 3, 3'd4, 2'b01, 1'b1, 3, 2);
        fillRandom(0, 1'b1);
        doWrite(BASE + 32'h0340, 0, 3'd4, 2'b01, 1'b1, 0, -1);
        doRead(BASE + 32'h0300, 4, 3'd4, 2'b01, 1'b1, 2);

        applyStimulus(40);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
